// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and constants for the rv32i hazard unit with multi-cycle execute support.
package hazard_unit_mc_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MC_IDLE,
        MC_BUSY
    } mc_state_e;

    localparam int unsigned REG_X0 = 0;

    // MEM result is younger than WB, so it wins when both match.
    function automatic fwd_sel_e fwd_sel(logic mem_hit, logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit bundle: register indices and control in, stall/flush/forward out.
interface hazard_unit_mc_if
    import hazard_unit_mc_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 5,
    parameter int unsigned CNT_WIDTH = 32
);
    logic [REG_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic                 RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE, perf_clr;
    logic                 stallF, stallD, stallE, flushD, flushE, flushM;
    fwd_sel_e             ForwardAE, ForwardBE;
    logic                 mc_busy, mc_done;
    logic [CNT_WIDTH-1:0] stall_cycles, flush_events;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE, perf_clr,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
        input  ForwardAE, ForwardBE, mc_busy, mc_done, stall_cycles, flush_events
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, McStartE, perf_clr,
        output stallF, stallD, stallE, flushD, flushE, flushM,
        output ForwardAE, ForwardBE, mc_busy, mc_done, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_unit_mc_ctrl.sv
// Multi-cycle execute controller: holds the EX instruction for MC_LATENCY cycles in total.
module hazard_mc_ctrl
    import hazard_unit_mc_pkg::*;
#(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mc_start,
    output logic mc_stall,
    output logic mc_done
);
    localparam logic [7:0] CntInit = 8'(MC_LATENCY - 2);

    mc_state_e  state;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (mc_start) begin
                        state <= MC_BUSY;
                        cnt   <= CntInit;
                    end
                end
                MC_BUSY: begin
                    if (cnt == 8'd0) begin
                        state <= MC_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= MC_IDLE;
            endcase
        end
    end

    // The first stall cycle is the cycle the op enters EX, so the stall cannot be registered.
    assign mc_stall = (state == MC_IDLE) ? mc_start : (cnt != 8'd0);
    assign mc_done  = (state == MC_BUSY) && (cnt == 8'd0);

endmodule

// File: rtl/hazard_unit_mc.sv
// rv32i hazard unit: forwarding, load-use stall, branch flush, multi-cycle hold, perf counters.
module hazard_unit_mc
    import hazard_unit_mc_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_unit_mc_if.slave  hz
);
    localparam logic [REG_WIDTH-1:0] RegZero = REG_WIDTH'(REG_X0);

    logic           mc_stall, mc_done_raw, lw_stall;
    logic           hit_m_a, hit_w_a, hit_m_b, hit_w_b;
    logic           ev_stall, ev_flush;
    fwd_sel_e       fwd_a, fwd_b;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    hazard_mc_ctrl #(
        .MC_LATENCY(MC_LATENCY)
    ) u_mc_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .mc_start (hz.McStartE),
        .mc_stall (mc_stall),
        .mc_done  (mc_done_raw)
    );

    always_comb begin
        hit_m_a  = hz.RegWriteM && (hz.RdM != RegZero) && (hz.RdM == hz.Rs1E);
        hit_w_a  = hz.RegWriteW && (hz.RdW != RegZero) && (hz.RdW == hz.Rs1E);
        hit_m_b  = hz.RegWriteM && (hz.RdM != RegZero) && (hz.RdM == hz.Rs2E);
        hit_w_b  = hz.RegWriteW && (hz.RdW != RegZero) && (hz.RdW == hz.Rs2E);
        fwd_a    = fwd_sel(hit_m_a, hit_w_a);
        fwd_b    = fwd_sel(hit_m_b, hit_w_b);
        lw_stall = hz.LoadE && (hz.RdE != RegZero) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign ev_stall     = rst_n & (lw_stall | mc_stall);
    assign ev_flush     = rst_n & hz.PCSrcE & ~mc_stall;
    assign hz.stallF    = ev_stall;
    assign hz.stallD    = ev_stall;
    assign hz.stallE    = rst_n & mc_stall;
    assign hz.flushM    = rst_n & mc_stall;
    assign hz.flushD    = ev_flush;
    assign hz.flushE    = rst_n & (lw_stall | hz.PCSrcE) & ~mc_stall;
    assign hz.mc_busy   = rst_n & mc_stall;
    assign hz.mc_done   = rst_n & mc_done_raw;
    assign hz.ForwardAE = rst_n ? fwd_a : FWD_RF;
    assign hz.ForwardBE = rst_n ? fwd_b : FWD_RF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.perf_clr) begin
                stall_cnt <= '0;
            end else if (ev_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (hz.perf_clr) begin
                flush_cnt <= '0;
            end else if (ev_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_events = flush_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed plus random bench for hazard_unit_mc, checked against a cycle-level reference model.
module tb_hazard_unit_mc;
    import hazard_unit_mc_pkg::*;

    localparam int unsigned L = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_WIDTH(5), .CNT_WIDTH(32)) hz ();
    hazard_unit_mc_if #(.REG_WIDTH(5), .CNT_WIDTH(4))  hz4 ();

    assign hz4.Rs1D      = hz.Rs1D;
    assign hz4.Rs2D      = hz.Rs2D;
    assign hz4.Rs1E      = hz.Rs1E;
    assign hz4.Rs2E      = hz.Rs2E;
    assign hz4.RdE       = hz.RdE;
    assign hz4.RdM       = hz.RdM;
    assign hz4.RdW       = hz.RdW;
    assign hz4.RegWriteM = hz.RegWriteM;
    assign hz4.RegWriteW = hz.RegWriteW;
    assign hz4.LoadE     = hz.LoadE;
    assign hz4.PCSrcE    = hz.PCSrcE;
    assign hz4.McStartE  = hz.McStartE;
    assign hz4.perf_clr  = hz.perf_clr;

    hazard_unit_mc #(.REG_WIDTH(5), .MC_LATENCY(L), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    hazard_unit_mc #(.REG_WIDTH(5), .MC_LATENCY(L), .CNT_WIDTH(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz4)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles remaining in the current multi-cycle op (0 = none in flight).
    int    mc_left = 0;
    longint sc32 = 0, fe32 = 0, sc4 = 0, fe4 = 0;

    function automatic longint sat_inc(longint v, longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic logic [1:0] fwd_ref(int rs, bit wm, int rdm, bit ww, int rdw);
        if (wm && rdm != 0 && rdm == rs) return 2'd2;
        if (ww && rdw != 0 && rdw == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.LoadE = 1'b0;
        hz.PCSrcE = 1'b0; hz.McStartE = 1'b0; hz.perf_clr = 1'b0;
    endtask

    // Compare one cycle mid-period, then advance the model across the rising edge.
    task automatic step();
        bit lw, mcs, done, e_sf, e_fd, e_fe;
        logic [1:0] fa, fb;
        #3;
        if (!rst_n) begin
            mc_left = 0; sc32 = 0; fe32 = 0; sc4 = 0; fe4 = 0;
        end
        if (rst_n && mc_left == 0) begin
            assert (!(hz.McStartE && (hz.LoadE || hz.PCSrcE))) else begin
                n_err++;
                $error("FAIL illegal_mc_combo: observed 1 expected 0");
            end
        end
        lw   = hz.LoadE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        mcs  = (mc_left == 0) ? hz.McStartE : (mc_left > 1);
        done = (mc_left == 1);
        fa   = fwd_ref(int'(hz.Rs1E), hz.RegWriteM, int'(hz.RdM), hz.RegWriteW, int'(hz.RdW));
        fb   = fwd_ref(int'(hz.Rs2E), hz.RegWriteM, int'(hz.RdM), hz.RegWriteW, int'(hz.RdW));
        if (!rst_n) begin
            lw = 0; mcs = 0; done = 0; fa = 2'd0; fb = 2'd0;
        end
        e_sf = rst_n && (lw || mcs);
        e_fd = rst_n && hz.PCSrcE && !mcs;
        e_fe = rst_n && (lw || hz.PCSrcE) && !mcs;
        chk("stallF",    64'(hz.stallF),    64'(e_sf));
        chk("stallD",    64'(hz.stallD),    64'(e_sf));
        chk("stallE",    64'(hz.stallE),    64'(mcs));
        chk("flushM",    64'(hz.flushM),    64'(mcs));
        chk("flushD",    64'(hz.flushD),    64'(e_fd));
        chk("flushE",    64'(hz.flushE),    64'(e_fe));
        chk("ForwardAE", 64'(hz.ForwardAE), 64'(fa));
        chk("ForwardBE", 64'(hz.ForwardBE), 64'(fb));
        chk("mc_busy",   64'(hz.mc_busy),   64'(mcs));
        chk("mc_done",   64'(hz.mc_done),   64'(done));
        chk("stall_cycles",    64'(hz.stall_cycles),  64'(sc32));
        chk("flush_events",    64'(hz.flush_events),  64'(fe32));
        chk("stall_cycles_w4", 64'(hz4.stall_cycles), 64'(sc4));
        chk("flush_events_w4", 64'(hz4.flush_events), 64'(fe4));
        @(posedge clk);
        if (rst_n) begin
            if (hz.perf_clr) begin
                sc32 = 0; fe32 = 0; sc4 = 0; fe4 = 0;
            end else begin
                if (e_sf) begin sc32 = sat_inc(sc32, 64'hFFFF_FFFF); sc4 = sat_inc(sc4, 15); end
                if (e_fd) begin fe32 = sat_inc(fe32, 64'hFFFF_FFFF); fe4 = sat_inc(fe4, 15); end
            end
            if (mc_left == 0) begin
                if (hz.McStartE) mc_left = L - 1;
            end else begin
                mc_left--;
            end
        end
        #1;
    endtask

    initial begin
        // Reset with a would-be stall and multi-cycle start on the inputs
        clear_in();
        rst_n = 1'b0;
        hz.McStartE = 1'b1; hz.LoadE = 1'b1; hz.RdE = 5'd2; hz.Rs1D = 5'd2;
        step();
        step();
        clear_in();
        rst_n = 1'b1;
        step();

        // Forwarding priority
        hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.RegWriteW = 1'b1; hz.RdW = 5'd5;
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5;
        step();
        hz.RegWriteM = 1'b0;
        step();
        hz.RdM = 5'd0; hz.RdW = 5'd0;
        step();

        // Load-use
        clear_in();
        hz.LoadE = 1'b1; hz.RdE = 5'd2; hz.Rs1D = 5'd3; hz.Rs2D = 5'd2;
        step();
        hz.RdE = 5'd0;
        step();

        // Branch flush, and branch together with load-use
        clear_in();
        hz.PCSrcE = 1'b1;
        repeat (3) step();
        hz.LoadE = 1'b1; hz.RdE = 5'd4; hz.Rs1D = 5'd4;
        step();

        // Multi-cycle op with a branch arriving while held
        clear_in();
        hz.perf_clr = 1'b1;
        step();
        hz.perf_clr = 1'b0;
        hz.McStartE = 1'b1;
        step();
        hz.PCSrcE = 1'b1;
        step();
        hz.PCSrcE = 1'b0;
        step();
        step();
        chk("mc_stall_total", 64'(hz.stall_cycles), 64'd3);
        hz.McStartE = 1'b0;
        step();

        // Reset during BUSY aborts without mc_done
        hz.McStartE = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        hz.McStartE = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();

        // Saturation of the narrow counter, then clear
        hz.perf_clr = 1'b1;
        step();
        hz.perf_clr = 1'b0;
        hz.LoadE = 1'b1; hz.RdE = 5'd1; hz.Rs1D = 5'd1;
        repeat (20) step();
        chk("sat_w4", 64'(hz4.stall_cycles), 64'd15);
        chk("count_w32", 64'(hz.stall_cycles), 64'd20);
        clear_in();
        hz.perf_clr = 1'b1;
        step();
        hz.perf_clr = 1'b0;
        chk("clr_w4", 64'(hz4.stall_cycles), 64'd0);
        step();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
            hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
            hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
            hz.RdW  = 5'($urandom_range(0, 3));
            hz.RegWriteM = 1'($urandom_range(0, 1));
            hz.RegWriteW = 1'($urandom_range(0, 1));
            hz.LoadE     = ($urandom_range(0, 3) == 0);
            hz.PCSrcE    = ($urandom_range(0, 5) == 0);
            hz.perf_clr  = ($urandom_range(0, 39) == 0);
            if (mc_left == 0) begin
                hz.McStartE = ($urandom_range(0, 7) == 0);
                if (hz.McStartE) begin
                    hz.LoadE = 1'b0; hz.PCSrcE = 1'b0;
                end
            end else begin
                hz.McStartE = 1'b1;
            end
            rst_n = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Next-generation pipeline hazard unit for the rv32i 5-stage core. Replaces the stall/flush-only unit.
- Adds EX-stage operand forwarding selects, load-use detection and branch flush.
- Adds a multi-cycle execute-op controller (FSM plus down-counter) that holds the EX instruction for MC_LATENCY cycles and inserts bubbles into MEM.
- Adds saturating performance counters for stall cycles and branch flushes.

Parameters:
REG_WIDTH, 5, register-index width
MC_LATENCY, 4, total EX-stage cycles of a multi-cycle op; legal range 2..255
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
Rs1D, Rs2D  input  REG_WIDTH  source registers in ID
Rs1E, Rs2E  input  REG_WIDTH  source registers in EX
RdE, RdM, RdW  input  REG_WIDTH  destination registers in EX/MEM/WB
RegWriteM, RegWriteW  input  1  MEM/WB instruction writes the register file
LoadE  input  1  EX instruction is a load (ResultSrcE selects memory)
PCSrcE  input  1  taken branch/jump resolved in EX
McStartE  input  1  EX instruction is a multi-cycle op
perf_clr  input  1  synchronous clear of the performance counters
stallF, stallD, stallE  output  1  hold PC, IF/ID and ID/EX registers
flushD, flushE, flushM  output  1  clear IF/ID, ID/EX and EX/MEM registers
ForwardAE, ForwardBE  output  2  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result
mc_busy  output  1  multi-cycle op in progress (stall active)
mc_done  output  1  final EX cycle of a multi-cycle op
stall_cycles  output  CNT_WIDTH  count of cycles with stallF=1
flush_events  output  CNT_WIDTH  count of cycles with flushD=1

Behaviour:
- Reset: rst_n low forces IDLE state, counter 0 and both perf counters 0. While rst_n is low, all stall/flush outputs, mc_busy and mc_done are 0, and ForwardAE/BE are 00. Reset during BUSY aborts the op with no mc_done pulse.
- Forwarding (combinational, same cycle):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - MEM has priority over WB. ForwardBE uses identical rules with Rs2E.
- Load-use: lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- MC FSM states: IDLE, BUSY. Let L=MC_LATENCY.
  - IDLE and McStartE: mc_stall=1; next state BUSY with cnt=L-2.
  - BUSY and cnt!=0: mc_stall=1; cnt decrements.
  - BUSY and cnt==0: mc_stall=0, mc_done=1; next state IDLE.
  - McStartE is ignored in BUSY (it is the same held instruction).
  - Result: an op entering EX in cycle t is stalled in cycles t..t+L-2 and advances to MEM after cycle t+L-1.
  - mc_busy=mc_stall.
- Outputs:
  - stallF = stallD = lwStall | mc_stall.
  - stallE = mc_stall.
  - flushM = mc_stall (bubble into MEM while EX is held).
  - flushD = PCSrcE & ~mc_stall.
  - flushE = (lwStall | PCSrcE) & ~mc_stall.
- Simultaneous events:
  - mc_stall overrides PCSrcE and lwStall flushes.
  - McStartE together with LoadE, or McStartE together with PCSrcE, is illegal. The bench asserts it never occurs; RTL behaviour follows the equations above.
  - lwStall together with PCSrcE gives stallF=stallD=1, flushD=1, flushE=1.
- Perf counters:
  - Each increments by 1 on a clock edge where its event was 1 in that cycle.
  - Each saturates at all-ones and does not wrap.
  - perf_clr sets a counter to 0 and wins over an increment in the same cycle.

Decomposition:
- rv32i_pkg additions:
  - fwd_sel_e enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - mc_state_e enum {MC_IDLE, MC_BUSY}.
  - constant REG_X0 = '0.
- One sub-module, hazard_mc_ctrl: FSM plus down-counter, output mc_stall/mc_done.
- Forwarding, load-use and counters stay in the top module.

Test Plan:
- Reset with rst_n=0 while McStartE=1 and LoadE=1 with RdE=Rs1D=2 -> all stall/flush outputs 0, counters 0.
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=5 -> ForwardAE=ForwardBE=10. Then RegWriteM=0 -> 01. Then RdM=RdW=0 -> 00.
- LoadE=1, RdE=2, Rs1D=3, Rs2D=2 -> stallF=stallD=flushE=1, stallE=0. Then RdE=0 -> all 0.
- PCSrcE=1 alone -> flushD=flushE=1, stall 0; flush_events increments by 1 per cycle.
- MC_LATENCY=4, McStartE=1 held for 4 cycles:
  - cycles 0-2: stallF/D/E=flushM=mc_busy=1.
  - cycle 3: mc_done=1, stalls 0.
  - stall_cycles=3.
  - PCSrcE=1 in cycle 1 -> flushD=flushE=0.
- rst_n pulsed low in cycle 1 of a BUSY op -> mc_busy=0 immediately, no mc_done. Separately, CNT_WIDTH=4 with 20 stall cycles -> stall_cycles=15, then perf_clr -> 0.
